dflip_flop: RTL and testbench
=============================

DFLIP_FLOP -- requirements
Module: dflip_flop

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 1: bit width of D, Q and Qbar.
- REQ-002 The block SHALL have parameter RESET_Q, default 0: value loaded into Q by rst; WIDTH bits.
- REQ-003 Port clk  input  1  SHALL be the single clock; all synchronous state changes occur on its rising edge.
- REQ-004 Port rst  input  1  SHALL be the reset: one clock; reset is asynchronous and active-high.
- REQ-005 Port clr  input  1  SHALL be a synchronous clear, active-low, sampled on rising clk.
- REQ-006 Port set  input  1  SHALL be a synchronous set, active-low, sampled on rising clk.
- REQ-007 Port D  input  WIDTH  SHALL be the data input, sampled on rising clk.
- REQ-008 Port Q  output  WIDTH  SHALL be the registered state.
- REQ-009 Port Qbar  output  WIDTH  SHALL be the bitwise complement of Q.

Function
- REQ-010 On rising clk with rst=0 and clr=0, Q SHALL become all zeros, regardless of set and D.
- REQ-011 On rising clk with rst=0, clr=1 and set=0, Q SHALL become all ones, regardless of D.
- REQ-012 On rising clk with rst=0, clr=1 and set=1, Q SHALL become D.
- REQ-013 Priority SHALL be rst > clr > set > D.
  - clr=0 together with set=0 yields Q=0.
- REQ-014 Latency SHALL be one edge: the new Q is visible immediately after the rising edge that sampled the inputs, and is held until the next qualifying event.
- REQ-015 Qbar SHALL equal ~Q at all times, including during and after reset.
  - Q and Qbar are never equal in any bit.
- REQ-016 Changes on clr, set or D between rising edges SHALL NOT affect Q; only rst acts asynchronously.
- REQ-017 Input values sampled are those present before the edge.
  - Inputs changed non-blockingly at the same edge take effect on the following edge.

Reset
- REQ-018 While rst=1, Q SHALL equal RESET_Q and Qbar SHALL equal ~RESET_Q, independent of clk, clr, set and D.
- REQ-019 Assertion of rst SHALL take effect immediately, without waiting for a clock edge.
- REQ-020 Reset mid-operation SHALL override any pending clocked update.
- REQ-021 After rst deasserts, the first rising clk SHALL apply REQ-010 to REQ-012 normally.

Structure
- REQ-022 No shared package is required; WIDTH and RESET_Q SHALL be module parameters only.
- REQ-023 The block SHALL be a single module with one clocked process for Q.
  - Qbar is continuous logic.
  - No sub-module.

Verification
- REQ-024 rst=1 asynchronous pulse mid-cycle with Q=1 -> Q=0 and Qbar=1 before the next edge, held while rst=1.
- REQ-025 rst=0, clr=1, set=1, D=1, then D=0 on successive edges -> Q=1/Qbar=0, then Q=0/Qbar=1.
- REQ-026 clr=0, set=1, D=1 at an edge -> Q=0, Qbar=1.
- REQ-027 clr=1, set=0, D=0 at an edge -> Q=1, Qbar=0.
- REQ-028 clr=0, set=0, D=1 at an edge -> Q=0 (clear wins).
- REQ-029 Sweep a 4-bit counter c over 0..15, one value per clock, with:
  - clr=0 for c in {2,5,6}, else 1;
  - set=0 for c in {1,2,6}, else 1;
  - D=c[2];
  - check Q/Qbar against REQ-010 to REQ-013 one time unit after every edge -> zero mismatches.

Source files
------------

// File: rtl/dflip_flop.sv
// dflip_flop -- parameterised D flip-flop with async reset and sync clear/set.
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous reset, active-high, loads RESET_Q
//   clr   in   1      synchronous clear, active-low (wins over set)
//   set   in   1      synchronous set, active-low
//   D     in   WIDTH  data input
//   Q     out  WIDTH  registered state
//   Qbar  out  WIDTH  bitwise complement of Q
module dflip_flop #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RESET_Q = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             set,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar
);

   logic [WIDTH-1:0] r_q;

   // Priority rst > clr > set > D.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q <= RESET_Q;
      else if (!clr)
         r_q <= '0;
      else if (!set)
         r_q <= '1;
      else
         r_q <= D;
   end

   assign Q    = r_q;
   assign Qbar = ~r_q;

endmodule

// File: tb/tb_dflip_flop.sv
module tb_dflip_flop;

   localparam logic [7:0] RQ8 = 8'hA5;

   logic       clk = 1'b0;
   logic       rst, clr, set;
   logic       d1;
   logic [7:0] d8;
   logic       q1, qb1;
   logic [7:0] q8, qb8;

   // reference state
   logic       e1;
   logic [7:0] e8;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dflip_flop u_dut1 (
      .clk (clk), .rst (rst), .clr (clr), .set (set),
      .D   (d1),  .Q   (q1),  .Qbar (qb1)
   );

   dflip_flop #(.WIDTH(8), .RESET_Q(RQ8)) u_dut8 (
      .clk (clk), .rst (rst), .clr (clr), .set (set),
      .D   (d8),  .Q   (q8),  .Qbar (qb8)
   );

   // Behavioural rule: what a flop holds after an edge given the sampled controls.
   function automatic logic [7:0] rule(input logic c, input logic s,
                                       input logic [7:0] d, input logic [7:0] ones);
      if (!c)      return 8'h00;
      else if (!s) return ones;
      else         return d;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".q1"},   {7'd0, q1},  {7'd0, e1});
      chk({tag, ".qb1"},  {7'd0, qb1}, {7'd0, ~e1});
      chk({tag, ".q8"},   q8,  e8);
      chk({tag, ".qb8"},  qb8, ~e8);
   endtask

   // Drive inputs at the falling edge, predict, then check 1 unit after the rising edge.
   task automatic step(input string tag, input logic c, input logic s,
                       input logic dd1, input logic [7:0] dd8);
      logic [7:0] t;
      @(negedge clk);
      clr = c; set = s; d1 = dd1; d8 = dd8;
      t  = rule(c, s, {7'd0, dd1}, 8'h01);
      e1 = t[0];
      e8 = rule(c, s, dd8, 8'hFF);
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   // Asynchronous reset pulse placed strictly between rising edges.
   task automatic async_rst(input string tag);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      e1 = 1'b0;
      e8 = RQ8;
      chk_all({tag, ".during"});
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all({tag, ".after"});
   endtask

   initial begin
      logic c_clr, c_set, r;
      logic [3:0] c;

      rst = 1'b1; clr = 1'b1; set = 1'b1; d1 = 1'b1; d8 = 8'h3C;
      e1 = 1'b0; e8 = RQ8;
      #1;
      chk_all("reset_t0");

      // reset held across edges with hostile inputs
      @(negedge clk);
      clr = 1'b1; set = 1'b0; d1 = 1'b1; d8 = 8'h0F;
      @(posedge clk); #1;
      chk_all("reset_held_edge");

      // first edges after release behave normally
      @(negedge clk);
      rst = 1'b0;
      step("d_one",  1'b1, 1'b1, 1'b1, 8'h5A);
      step("d_zero", 1'b1, 1'b1, 1'b0, 8'hC3);
      step("d_one2", 1'b1, 1'b1, 1'b1, 8'h7E);

      // mid-cycle reset with Q=1, then reset held through an edge
      @(posedge clk); #2;
      rst = 1'b1; #1;
      e1 = 1'b0; e8 = RQ8;
      chk_all("async_rst_mid");
      @(posedge clk); #1;
      chk_all("async_rst_hold");
      @(negedge clk);
      rst = 1'b0;

      step("clr_only",  1'b0, 1'b1, 1'b1, 8'hFF);
      step("set_only",  1'b1, 1'b0, 1'b0, 8'h00);
      step("clr_wins",  1'b0, 1'b0, 1'b1, 8'hFF);
      step("set_again", 1'b1, 1'b0, 1'b0, 8'h12);

      // inputs wiggling between edges must not move Q
      @(negedge clk);
      clr = 1'b0; #1; set = 1'b0; #1; d1 = 1'b0; d8 = 8'h00; #1;
      clr = 1'b1; set = 1'b1; d1 = 1'b1; #1;
      chk_all("between_edges");

      // counter sweep
      for (int i = 0; i < 16; i++) begin
         c     = 4'(i);
         c_clr = !(i == 2 || i == 5 || i == 6);
         c_set = !(i == 1 || i == 2 || i == 6);
         step($sformatf("sweep%0d", i), c_clr, c_set, c[2], {4'h0, c});
      end

      // randomized traffic with occasional async reset pulses
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            async_rst($sformatf("rnd_rst%0d", i));
         end else begin
            c_clr = ($urandom_range(0, 4) != 0);
            c_set = ($urandom_range(0, 3) != 0);
            r     = 1'($urandom);
            step($sformatf("rnd%0d", i), c_clr, c_set, r, 8'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
